// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared types for the multiply/divide sequencer: operation encodings,
// the sequencer state enum, the exception-cause encoding and the packed
// bundle of registered control outputs.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_DIVM = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4,
    ST_EXC  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_DIV0    = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_e;

  typedef struct packed {
    logic multControl;
    logic multReset;
    logic divOp;
    logic divReset;
    logic divmSel;
    logic hiW;
    logic loW;
    logic busy;
    logic done;
    logic excDiv0;
    logic excTimeout;
  } seq_out_t;

  // DIV and DIVM share the divider unit and its flags.
  function automatic logic isDivOp(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_watchdog.sv
// cycle_watchdog
// Counts cycles while enabled and flags when the count reaches TIMEOUT-1,
// so the sequencer can abandon a unit that never raises its completion flag.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   clear_i    zero the counter (takes priority over enable)
//   enable_i   advance the counter by one this cycle
//   expired_o  counter currently equals TIMEOUT-1
module cycle_watchdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cntQ;
  logic [CNT_W-1:0] cntD;

  // Clear wins over enable so the sequencer can zero the count on the
  // cycle just before the unit starts running.
  always_comb begin
    cntD = cntQ;
    if (clear_i) begin
      cntD = '0;
    end else if (enable_i) begin
      cntD = cntQ + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  // The count equals the index of the current RUN cycle, so matching
  // TIMEOUT-1 means this is the last cycle the unit is allowed.
  assign expired_o = (cntQ == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Runs the shared multiplier or divider for the control unit: clears the
// selected unit, runs it until its completion flag, writes HI/LO, then
// pulses done. Divide-by-zero and a watchdog timeout end the operation
// with an exception pulse instead, leaving HI/LO untouched.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_i, op_i       one-cycle request and operation (sampled in IDLE)
//   mult_end_i          multiplier finished
//   div_done_i          divider finished
//   div_by0_i           divider divide-by-zero flag
//   mult_control_o      multiplier run enable
//   mult_reset_o        multiplier clear
//   div_op_o            divider run enable / HI-LO source select
//   div_reset_o         divider clear
//   divm_sel_o          divider operands from the DIVM path
//   hi_w_o, lo_w_o      HI / LO write enables
//   busy_o              operation in progress
//   done_o              one-cycle pulse, HI/LO written
//   exc_div0_o          one-cycle pulse, divide by zero
//   exc_timeout_o       one-cycle pulse, watchdog expired
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] op_i,
  input  logic       mult_end_i,
  input  logic       div_done_i,
  input  logic       div_by0_i,
  output logic       mult_control_o,
  output logic       mult_reset_o,
  output logic       div_op_o,
  output logic       div_reset_o,
  output logic       divm_sel_o,
  output logic       hi_w_o,
  output logic       lo_w_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       exc_div0_o,
  output logic       exc_timeout_o
);

  state_e   stateQ, stateD;
  op_e      opQ, opD;
  cause_e   causeQ, causeD;
  seq_out_t outsQ, outsD;

  logic unitDone;
  logic wdExpired;

  cycle_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) uWatchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (stateQ == ST_CLR),
    .enable_i  (stateQ == ST_RUN),
    .expired_o (wdExpired)
  );

  // Only the flag of the unit actually running can end RUN; the other
  // unit's flag is ignored.
  assign unitDone = (opQ == OP_MULT) ? mult_end_i : div_done_i;

  // Next-state logic. In RUN a divide-by-zero beats completion, and
  // completion beats the watchdog, so a result arriving on the very last
  // allowed cycle is still written back. The reserved op is accepted but
  // skips the units entirely and reports done straight away.
  always_comb begin
    stateD = stateQ;
    opD    = opQ;
    causeD = causeQ;
    case (stateQ)
      ST_IDLE: begin
        if (start_i) begin
          opD    = op_e'(op_i);
          causeD = CAUSE_NONE;
          stateD = (op_e'(op_i) == OP_RSVD) ? ST_DONE : ST_CLR;
        end
      end
      ST_CLR: begin
        stateD = ST_RUN;
      end
      ST_RUN: begin
        if (isDivOp(opQ) && div_by0_i) begin
          stateD = ST_EXC;
          causeD = CAUSE_DIV0;
        end else if (unitDone) begin
          stateD = ST_WB;
        end else if (wdExpired) begin
          stateD = ST_EXC;
          causeD = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        stateD = ST_DONE;
      end
      ST_DONE: begin
        stateD = ST_IDLE;
      end
      ST_EXC: begin
        stateD = ST_IDLE;
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state and op, so the registered
  // outputs line up with the state they belong to. In WB the divider
  // select stays up so the HI/LO mux still picks the divider results.
  always_comb begin
    outsD = '0;
    case (stateD)
      ST_CLR: begin
        outsD.busy = 1'b1;
        if (opD == OP_MULT) begin
          outsD.multReset = 1'b1;
        end else begin
          outsD.divReset = 1'b1;
        end
      end
      ST_RUN: begin
        outsD.busy        = 1'b1;
        outsD.multControl = (opD == OP_MULT);
        outsD.divOp       = isDivOp(opD);
        outsD.divmSel     = (opD == OP_DIVM);
      end
      ST_WB: begin
        outsD.busy    = 1'b1;
        outsD.hiW     = 1'b1;
        outsD.loW     = 1'b1;
        outsD.divOp   = isDivOp(opD);
        outsD.divmSel = (opD == OP_DIVM);
      end
      ST_DONE: begin
        outsD.done = 1'b1;
      end
      ST_EXC: begin
        outsD.excDiv0    = (causeD == CAUSE_DIV0);
        outsD.excTimeout = (causeD == CAUSE_TIMEOUT);
      end
      default: begin
        outsD = '0;
      end
    endcase
  end

  // State, latched op/cause and registered outputs. Reset drops everything
  // at once, abandoning any operation without a write or a pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stateQ <= ST_IDLE;
      opQ    <= OP_MULT;
      causeQ <= CAUSE_NONE;
      outsQ  <= '0;
    end else begin
      stateQ <= stateD;
      opQ    <= opD;
      causeQ <= causeD;
      outsQ  <= outsD;
    end
  end

  assign mult_control_o = outsQ.multControl;
  assign mult_reset_o   = outsQ.multReset;
  assign div_op_o       = outsQ.divOp;
  assign div_reset_o    = outsQ.divReset;
  assign divm_sel_o     = outsQ.divmSel;
  assign hi_w_o         = outsQ.hiW;
  assign lo_w_o         = outsQ.loW;
  assign busy_o         = outsQ.busy;
  assign done_o         = outsQ.done;
  assign exc_div0_o     = outsQ.excDiv0;
  assign exc_timeout_o  = outsQ.excTimeout;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Directed bench for muldiv_sequencer. Two instances share the data-side
// inputs: one with the default watchdog (64) for the normal flows and one
// with an 8-cycle watchdog for the timeout case. Each step drives inputs,
// clocks once, and compares the full 11-bit output vector against a
// hand-written expectation one time unit after the edge.
module tb_muldiv_sequencer;

  logic       clk;
  logic       reset;
  logic       start64;
  logic       start8;
  logic [1:0] op;
  logic       mult_end;
  logic       div_done;
  logic       div_by0;

  logic mc64, mr64, dop64, dr64, dms64, hiw64, low64, busy64, done64, ed64, et64;
  logic mc8, mr8, dop8, dr8, dms8, hiw8, low8, busy8, done8, ed8, et8;

  logic [10:0] outs64;
  logic [10:0] outs8;

  int checks;
  int errors;

  localparam logic [10:0] NONE = 11'd0;
  localparam logic [10:0] MCTL = 11'd1 << 10;
  localparam logic [10:0] MRST = 11'd1 << 9;
  localparam logic [10:0] DOP  = 11'd1 << 8;
  localparam logic [10:0] DRST = 11'd1 << 7;
  localparam logic [10:0] DMS  = 11'd1 << 6;
  localparam logic [10:0] HIW  = 11'd1 << 5;
  localparam logic [10:0] LOW  = 11'd1 << 4;
  localparam logic [10:0] BUSY = 11'd1 << 3;
  localparam logic [10:0] DONE = 11'd1 << 2;
  localparam logic [10:0] ED0  = 11'd1 << 1;
  localparam logic [10:0] ETO  = 11'd1;

  muldiv_sequencer #(
    .TIMEOUT (64),
    .CNT_W   (7)
  ) dut64 (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start64),
    .op_i           (op),
    .mult_end_i     (mult_end),
    .div_done_i     (div_done),
    .div_by0_i      (div_by0),
    .mult_control_o (mc64),
    .mult_reset_o   (mr64),
    .div_op_o       (dop64),
    .div_reset_o    (dr64),
    .divm_sel_o     (dms64),
    .hi_w_o         (hiw64),
    .lo_w_o         (low64),
    .busy_o         (busy64),
    .done_o         (done64),
    .exc_div0_o     (ed64),
    .exc_timeout_o  (et64)
  );

  muldiv_sequencer #(
    .TIMEOUT (8),
    .CNT_W   (4)
  ) dut8 (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start8),
    .op_i           (op),
    .mult_end_i     (mult_end),
    .div_done_i     (div_done),
    .div_by0_i      (div_by0),
    .mult_control_o (mc8),
    .mult_reset_o   (mr8),
    .div_op_o       (dop8),
    .div_reset_o    (dr8),
    .divm_sel_o     (dms8),
    .hi_w_o         (hiw8),
    .lo_w_o         (low8),
    .busy_o         (busy8),
    .done_o         (done8),
    .exc_div0_o     (ed8),
    .exc_timeout_o  (et8)
  );

  assign outs64 = {mc64, mr64, dop64, dr64, dms64, hiw64, low64, busy64, done64, ed64, et64};
  assign outs8  = {mc8, mr8, dop8, dr8, dms8, hiw8, low8, busy8, done8, ed8, et8};

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, clock once, and settle just past
  // the edge so the registered outputs of the new state can be read.
  task automatic applyStimulus(input logic rst, input logic st64, input logic st8,
                               input logic [1:0] opv, input logic mend,
                               input logic ddone, input logic dby0);
    reset    = rst;
    start64  = st64;
    start8   = st8;
    op       = opv;
    mult_end = mend;
    div_done = ddone;
    div_by0  = dby0;
    @(posedge clk);
    #1;
  endtask

  // Compare one output vector and count the result.
  task automatic checkOutput(input string tag, input logic [10:0] observed,
                             input logic [10:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Directed sequence covering every flow in order.
  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start64  = 1'b0;
    start8   = 1'b0;
    op       = 2'b00;
    mult_end = 1'b0;
    div_done = 1'b0;
    div_by0  = 1'b0;

    // Power-on reset, including a start held during reset.
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0);
    applyStimulus(1, 1, 1, 2'b11, 0, 0, 0);
    checkOutput("reset64", outs64, NONE);
    checkOutput("reset8", outs8, NONE);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("idle64", outs64, NONE);

    // MULT, completion on the 33rd RUN cycle; divider flags must be ignored.
    $display("[TB] MULT flow");
    applyStimulus(0, 1, 0, 2'b00, 0, 0, 0);
    checkOutput("mult_clr", outs64, MRST | BUSY);
    for (int k = 0; k < 33; k++) begin
      applyStimulus(0, 0, 0, 2'b00, 0, (k == 5), (k == 6));
      checkOutput("mult_run", outs64, MCTL | BUSY);
    end
    applyStimulus(0, 0, 0, 2'b00, 1, 0, 0);
    checkOutput("mult_wb", outs64, HIW | LOW | BUSY);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("mult_done", outs64, DONE);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("mult_idle", outs64, NONE);

    // DIV, completion on the 20th RUN cycle; mult_end must be ignored.
    $display("[TB] DIV flow");
    applyStimulus(0, 1, 0, 2'b01, 0, 0, 0);
    checkOutput("div_clr", outs64, DRST | BUSY);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 0, 2'b00, (k == 3), 0, 0);
      checkOutput("div_run", outs64, DOP | BUSY);
    end
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("div_wb", outs64, DOP | HIW | LOW | BUSY);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("div_done", outs64, DONE);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("div_idle", outs64, NONE);

    // DIV with div_by0 and div_done together on RUN cycle 5.
    $display("[TB] DIV by zero flow");
    applyStimulus(0, 1, 0, 2'b01, 0, 0, 0);
    checkOutput("div0_clr", outs64, DRST | BUSY);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
      checkOutput("div0_run", outs64, DOP | BUSY);
    end
    applyStimulus(0, 0, 0, 2'b01, 0, 1, 1);
    checkOutput("div0_exc", outs64, ED0);
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
    checkOutput("div0_idle", outs64, NONE);
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
    checkOutput("div0_quiet", outs64, NONE);

    // Watchdog on the 8-cycle instance: MULT with mult_end held low.
    $display("[TB] timeout flow");
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 0);
    checkOutput("to_clr", outs8, MRST | BUSY);
    checkOutput("to_other_idle", outs64, NONE);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
      checkOutput("to_run", outs8, MCTL | BUSY);
    end
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("to_exc", outs8, ETO);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("to_idle", outs8, NONE);
    applyStimulus(0, 0, 1, 2'b01, 0, 0, 0);
    checkOutput("to_restart", outs8, DRST | BUSY);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("to_restart_run", outs8, DOP | BUSY);
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("to_restart_wb", outs8, DOP | HIW | LOW | BUSY);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("to_restart_done", outs8, DONE);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("to_restart_idle", outs8, NONE);

    // Start with op=01 mid-MULT is ignored; the latched op stays MULT.
    $display("[TB] ignored start and reserved op");
    applyStimulus(0, 1, 0, 2'b00, 0, 0, 0);
    checkOutput("ign_clr", outs64, MRST | BUSY);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, (k == 3), 0, (k >= 3) ? 2'b01 : 2'b00, 0, 0, 0);
      checkOutput("ign_run", outs64, MCTL | BUSY);
    end
    applyStimulus(0, 0, 0, 2'b01, 1, 0, 0);
    checkOutput("ign_wb", outs64, HIW | LOW | BUSY);
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
    checkOutput("ign_done", outs64, DONE);
    applyStimulus(0, 1, 0, 2'b11, 0, 0, 0);
    checkOutput("ign_start_in_done", outs64, NONE);
    applyStimulus(0, 1, 0, 2'b11, 0, 0, 0);
    checkOutput("rsvd_done", outs64, DONE);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("rsvd_idle", outs64, NONE);

    // Reset on RUN cycle 3 of a DIVM, with div_done raised at the same time.
    $display("[TB] reset mid-operation");
    applyStimulus(0, 1, 0, 2'b10, 0, 0, 0);
    checkOutput("rst_clr", outs64, DRST | BUSY);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 2'b10, 0, 0, 0);
      checkOutput("rst_run", outs64, DOP | DMS | BUSY);
    end
    applyStimulus(1, 0, 0, 2'b10, 0, 1, 0);
    checkOutput("rst_abort", outs64, NONE);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 2'b10, 0, 0, 0);
      checkOutput("rst_quiet", outs64, NONE);
    end
    applyStimulus(0, 1, 0, 2'b10, 0, 0, 0);
    checkOutput("rst_new_clr", outs64, DRST | BUSY);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("rst_new_run", outs64, DOP | DMS | BUSY);
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    checkOutput("rst_new_wb", outs64, DOP | DMS | HIW | LOW | BUSY);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("rst_new_done", outs64, DONE);
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("rst_new_idle", outs64, NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared multiplier and divider units for the multicycle CPU, on behalf of the control unit.
- Clears the selected unit, runs it, waits for its completion flag, then writes HI/LO.
- Reports divide-by-zero and watchdog-timeout exceptions.
- Lets the control unit issue one start pulse and wait on done/exception instead of driving mult_control, mult_reset, DivOp and div_reset itself.

Parameters:
TIMEOUT, 64, maximum cycles spent in RUN before a timeout exception is raised
CNT_W, 7, width of the RUN-cycle counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request from the control unit; sampled only in IDLE
op  in  2  operation: 00 MULT, 01 DIV, 10 DIVM, 11 reserved
mult_end  in  1  multiplier finished
div_done  in  1  divider finished
div_by0  in  1  divider divide-by-zero flag
mult_control  out  1  multiplier run enable
mult_reset  out  1  multiplier clear
div_op  out  1  divider run enable; also selects divider results onto the HI/LO inputs
div_reset  out  1  divider clear
divm_sel  out  1  routes divider operands from the DIVM path
hi_w  out  1  HI write enable
lo_w  out  1  LO write enable
busy  out  1  operation in progress
done  out  1  one-cycle pulse: HI/LO written successfully
exc_div0  out  1  one-cycle pulse: divide by zero, HI/LO untouched
exc_timeout  out  1  one-cycle pulse: watchdog expired, HI/LO untouched

Behaviour:
- Reset: state IDLE, counter 0, latched op 0, every output 0. Reset mid-operation aborts immediately; no HI/LO write and no pulse follows.
- States: IDLE, CLR, RUN, WB, DONE, EXC.
- IDLE:
  - start=1 latches op and moves to CLR, except op=11, which goes straight to DONE (no unit activity, no write).
  - start with any op in states other than IDLE is ignored.
- CLR (1 cycle): busy=1. MULT asserts mult_reset=1; DIV/DIVM assert div_reset=1. Counter cleared. Next state RUN.
- RUN: busy=1, counter increments each cycle.
  - MULT: mult_control=1. DIV: div_op=1. DIVM: div_op=1 and divm_sel=1.
  - Priority, evaluated each cycle:
    1. div_by0=1 (DIV/DIVM only) → EXC with div0 cause.
    2. Completion flag high (mult_end for MULT, div_done for DIV/DIVM) → WB.
    3. Counter == TIMEOUT-1 → EXC with timeout cause.
  - div_by0 and div_done high in the same cycle: the exception wins.
  - mult_end is ignored for DIV ops; div_done is ignored for MULT.
- WB (1 cycle): busy=1, hi_w=lo_w=1. div_op and divm_sel stay as in RUN so the HI/LO mux keeps selecting divider results. Next state DONE.
- DONE (1 cycle): done=1, busy=0. Next state IDLE.
- EXC (1 cycle): exc_div0 or exc_timeout=1 according to the latched cause, busy=0, no writes. Next state IDLE.
- Latency:
  - start sampled at cycle N → CLR at N+1, RUN from N+2.
  - Completion seen at cycle M → hi_w/lo_w at M+1, done at M+2.
  - Earliest accepted next start is at M+3.
- Outputs are Moore (decoded from state and latched op), except the RUN exit decision.
- Exactly one of done, exc_div0, exc_timeout pulses per accepted start.

Decomposition:
- Package muldiv_pkg:
  - op encodings: OP_MULT, OP_DIV, OP_DIVM, OP_RSVD
  - state enum
  - exception-cause encoding
- Sub-module cycle_watchdog: counter with clear/enable inputs and an expired output at TIMEOUT-1. Parameterised by TIMEOUT and CNT_W.

Test Plan:
- MULT, bench multiplier raises mult_end 33 cycles into RUN (start at cycle 10):
  - mult_reset at 11; mult_control 12..44; hi_w=lo_w at 45; done at 46; busy high 11..45.
- DIV, div_done after 20 RUN cycles:
  - div_op high through WB; hi_w/lo_w one cycle; done one cycle later; mult_control never asserted.
- DIV with div_by0 and div_done both raised on RUN cycle 5:
  - exc_div0 pulses once; hi_w/lo_w never asserted; done never asserted.
- TIMEOUT=8, MULT with mult_end held low:
  - exc_timeout pulses exactly 8 cycles after entering RUN; returns to IDLE; next start accepted.
- start pulsed with op=01 during RUN of a MULT, and op=11 from IDLE:
  - first is ignored and the MULT completes normally; op=11 gives done one cycle after start with no unit signals.
- reset asserted at RUN cycle 3 of a DIVM:
  - next cycle all outputs 0, state IDLE; no done/exc pulse; a new start then behaves as from power-on.
